bram_stream_loader: RTL and testbench

- Upstream fill stage for the multi-bank BRAM.
- Accepts a stream of WIDTH-bit words over a valid/ready/last handshake and distributes them across BANKS banks in round-robin order (word 0 to bank 0, word 1 to bank 1, and so on).
- The bank address increments after each full round of banks.
- Drives the BRAM write port A slices directly and reports completion and overflow to the control logic.

---
 rtl/bram_stream_loader.sv | 107 ++++++++++
 tb/tb_bram_stream_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_loader.sv
// Stream-to-BRAM fill stage: spreads accepted words round-robin across BANKS
// write ports, one write per cycle, with a one-cycle registered write latency.
module bram_stream_loader #(
  parameter int BANKS = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int ADDR  = $clog2(DEPTH),
  parameter int WE    = WIDTH / 8,
  parameter int CNT   = $clog2(BANKS * DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [BANKS-1:0]       ena,
  output logic [BANKS*WE-1:0]    wea,
  output logic [BANKS*ADDR-1:0]  addra,
  output logic [BANKS*WIDTH-1:0] dina,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [CNT-1:0]         words
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [BW-1:0]   LAST_BANK = BW'(BANKS - 1);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
  localparam logic [CNT-1:0]  CAP       = CNT'(BANKS * DEPTH);

  // Handshake: a word transfers on any rising edge where s_tvalid and
  // s_tready are both high; s_tready depends only on state, never on s_tvalid.
  typedef enum logic [1:0] {IDLE, LOAD, DONE_S} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   bank_q;
  logic [ADDR-1:0] addr_q;
  logic            wr_pend;
  logic [BW-1:0]   wr_bank;
  logic            accept;
  logic            final_slot;

  assign accept     = s_tvalid & s_tready;
  assign final_slot = (bank_q == LAST_BANK) && (addr_q == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && (s_tlast || final_slot)) state_nxt = DONE_S;
      DONE_S:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_tready = (state == LOAD);
    busy     = (state == LOAD);
    done     = (state == DONE_S);
    ena      = '0;
    if (wr_pend) ena[wr_bank] = 1'b1;
    wea = '0;
    for (int b = 0; b < BANKS; b++) wea[b*WE +: WE] = {WE{ena[b]}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q   <= '0;
      addr_q   <= '0;
      wr_pend  <= 1'b0;
      wr_bank  <= '0;
      words    <= '0;
      overflow <= 1'b0;
      addra    <= '0;
      dina     <= '0;
    end else begin
      wr_pend <= accept;
      if (accept) wr_bank <= bank_q;
      if (state == IDLE && start) begin
        bank_q   <= '0;
        addr_q   <= '0;
        words    <= '0;
        overflow <= 1'b0;
      end else if (accept) begin
        if (words != CAP) words <= words + 1'b1;
        if (bank_q == LAST_BANK) begin
          bank_q <= '0;
          addr_q <= addr_q + 1'b1;
        end else begin
          bank_q <= bank_q + 1'b1;
        end
        // Filling the last slot without tlast means the stream is longer than memory.
        if (final_slot && !s_tlast) overflow <= 1'b1;
        addra[bank_q*ADDR +: ADDR]  <= addr_q;
        dina[bank_q*WIDTH +: WIDTH] <= s_tdata;
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench: default 4x256 loader driven from a vector table, plus a
// 2-bank/4-deep instance for the capacity and overflow corner cases.
module tb_bram_stream_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: BANKS=4 WIDTH=16 DEPTH=256 -> ADDR=8 WE=2 CNT=11
  logic        start = 0, s_tvalid = 0, s_tlast = 0;
  logic [15:0] s_tdata = '0;
  logic        s_tready, busy, done, overflow;
  logic [3:0]  ena;
  logic [7:0]  wea;
  logic [31:0] addra;
  logic [63:0] dina;
  logic [10:0] words;

  bram_stream_loader dut (
    .clk(clk), .rst(rst), .start(start), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .busy(busy), .done(done), .overflow(overflow), .words(words)
  );

  // Small instance: BANKS=2 WIDTH=16 DEPTH=4 -> ADDR=2 WE=2 CNT=4
  logic        start2 = 0, s_tvalid2 = 0, s_tlast2 = 0;
  logic [15:0] s_tdata2 = '0;
  logic        s_tready2, busy2, done2, overflow2;
  logic [1:0]  ena2;
  logic [3:0]  wea2;
  logic [3:0]  addra2;
  logic [31:0] dina2;
  logic [3:0]  words2;

  bram_stream_loader #(.BANKS(2), .WIDTH(16), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .s_tdata(s_tdata2), .s_tvalid(s_tvalid2),
    .s_tlast(s_tlast2), .s_tready(s_tready2), .ena(ena2), .wea(wea2), .addra(addra2),
    .dina(dina2), .busy(busy2), .done(done2), .overflow(overflow2), .words(words2)
  );

  typedef struct {
    logic [15:0] data;
    int          bnk;
    int          adr;
  } vec_t;

  vec_t tv[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", s_tready, 1);
    chk("start_words", words, 0);
    chk("start_ovf", overflow, 0);
  endtask

  // Applies tv[0..n-1] with tlast on the last word; optional idle cycle
  // between words and an optional start pulse that must be ignored.
  task automatic run_vec(input int n, input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) begin
      s_tdata  = tv[i].data;
      s_tvalid = 1'b1;
      s_tlast  = (i == n - 1);
      start    = (i == start_at);
      @(posedge clk); #1;
      start = 1'b0;
      chk("ena", ena, 64'(4'b0001 << tv[i].bnk));
      chk("wea", wea, 64'(8'b0000_0011 << (2 * tv[i].bnk)));
      chk("addra", addra[tv[i].bnk*8 +: 8], 64'(tv[i].adr));
      chk("dina", dina[tv[i].bnk*16 +: 16], tv[i].data);
      chk("done_timing", done, (i == n - 1));
      if (gaps && i != n - 1) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        chk("gap_ena", ena, 0);
        chk("gap_wea", wea, 0);
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(posedge clk); #1;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_ena", ena, 0);
    chk("post_words", words, 64'(n));
    chk("post_ovf", overflow, 0);
  endtask

  initial begin
    tv[0] = '{16'h00A0, 0, 0};
    tv[1] = '{16'h00A1, 1, 0};
    tv[2] = '{16'h00A2, 2, 0};
    tv[3] = '{16'h00A3, 3, 0};
    tv[4] = '{16'h00A4, 0, 1};
    tv[5] = '{16'h00A5, 1, 1};
    tv[6] = '{16'h00A6, 2, 1};
    tv[7] = '{16'h00A7, 3, 1};
    tv[8] = '{16'h00A8, 0, 2};
    tv[9] = '{16'h00A9, 1, 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ena", ena, 0);
    chk("rst_wea", wea, 0);
    chk("rst_ready", s_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_words", words, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", s_tready, 0);

    // Four words, one per bank at address 0
    do_start();
    run_vec(4, 1'b0, -1);
    // Ten words crossing two address rows
    do_start();
    run_vec(10, 1'b0, -1);
    // Same ten words with an idle cycle between each
    do_start();
    run_vec(10, 1'b1, -1);
    // start pulsed mid-load must not disturb the counters
    do_start();
    run_vec(5, 1'b0, 2);

    // Asynchronous reset after the third accept
    do_start();
    for (int i = 0; i < 3; i++) begin
      s_tdata  = tv[i].data;
      s_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_rst_ena", ena, 64'(4'b0100));
    rst = 1'b1;
    #1;
    chk("arst_ena", ena, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", s_tready, 0);
    chk("arst_words", words, 0);
    s_tvalid = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_idle", busy, 0);
    do_start();
    run_vec(1, 1'b0, -1);

    // Small instance: 9 words, no tlast -> overflow after 8
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("s2_busy", busy2, 1);
    for (int i = 0; i < 8; i++) begin
      s_tdata2  = 16'h0100 + 16'(i);
      s_tvalid2 = 1'b1;
      s_tlast2  = 1'b0;
      @(posedge clk); #1;
      chk("s2_ena", ena2, 64'(2'b01 << (i % 2)));
      chk("s2_wea", wea2, 64'(4'b0011 << (2 * (i % 2))));
      chk("s2_addra", addra2[(i%2)*2 +: 2], 64'(i / 2));
      chk("s2_dina", dina2[(i%2)*16 +: 16], 64'(16'h0100 + 16'(i)));
      chk("s2_done", done2, (i == 7));
    end
    chk("s2_final_bank1", ena2, 64'(2'b10));
    chk("s2_final_addr3", addra2[3:2], 3);
    chk("s2_ovf", overflow2, 1);
    chk("s2_ready_done", s_tready2, 0);
    s_tdata2 = 16'h0108;
    @(posedge clk); #1;
    chk("s2_9th_ena", ena2, 0);
    chk("s2_9th_ready", s_tready2, 0);
    chk("s2_9th_words", words2, 8);
    chk("s2_ovf_sticky", overflow2, 1);
    chk("s2_done_pulse", done2, 0);
    s_tvalid2 = 1'b0;
    @(posedge clk); #1;

    // Small instance: tlast on the final slot -> no overflow
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("s2b_ovf_clr", overflow2, 0);
    chk("s2b_words_clr", words2, 0);
    for (int i = 0; i < 8; i++) begin
      s_tdata2  = 16'h0200 + 16'(i);
      s_tvalid2 = 1'b1;
      s_tlast2  = (i == 7);
      @(posedge clk); #1;
      chk("s2b_ena", ena2, 64'(2'b01 << (i % 2)));
      chk("s2b_addra", addra2[(i%2)*2 +: 2], 64'(i / 2));
    end
    chk("s2b_done", done2, 1);
    chk("s2b_ovf", overflow2, 0);
    s_tvalid2 = 1'b0;
    s_tlast2  = 1'b0;
    @(posedge clk); #1;
    chk("s2b_words", words2, 8);
    chk("s2b_ovf_idle", overflow2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
